// File: rtl/ack_sched_pkg.sv
// rtl/ack_sched_pkg.sv - shared types and constants for the ACK return scheduler
package ack_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } ack_state_e;

    // ACKs returned by one piggybacked ACK bit
    localparam int ACK_CHUNK = 8;
    // Width of the pending ACK count
    localparam int CNT_W     = 8;

endpackage

// File: rtl/ack_scheduler_if.sv
// rtl/ack_scheduler_if.sv - ACK counter / flit packer / TX arbiter signals around the scheduler
//  slave  : the scheduler's view (i_* in, o_* out)
//  master : the surrounding link-layer logic's view
interface ack_scheduler_if;
    import ack_sched_pkg::*;

    logic             i_ack_en;
    logic [CNT_W-1:0] i_retry_num_ack;
    logic             i_retry_set_ack_bit;
    logic             i_force_ack;
    logic             i_tx_flit_valid;
    logic             i_tx_flit_ready;
    logic             o_tx_ack_bit;
    logic             o_dec_num_ack;
    logic             o_llcrd_req;
    logic             i_llcrd_gnt;
    logic             o_llcrd_full_ack_sent;
    logic [CNT_W-1:0] o_llcrd_ack_cnt;

    modport slave (
        input  i_ack_en, i_retry_num_ack, i_retry_set_ack_bit, i_force_ack,
               i_tx_flit_valid, i_tx_flit_ready, i_llcrd_gnt,
        output o_tx_ack_bit, o_dec_num_ack, o_llcrd_req,
               o_llcrd_full_ack_sent, o_llcrd_ack_cnt
    );

    modport master (
        output i_ack_en, i_retry_num_ack, i_retry_set_ack_bit, i_force_ack,
               i_tx_flit_valid, i_tx_flit_ready, i_llcrd_gnt,
        input  o_tx_ack_bit, o_dec_num_ack, o_llcrd_req,
               o_llcrd_full_ack_sent, o_llcrd_ack_cnt
    );

endinterface

// File: rtl/ack_timeout_timer.sv
// rtl/ack_timeout_timer.sv - saturating up-counter with clear/enable and terminal-count flag
//  i_clk, i_rst_n : clock, synchronous active-low reset
//  i_clr          : clear to 0 (wins over enable)
//  i_en           : count up, saturating at MAX
//  o_tc           : counter equals MAX
module ack_timeout_timer #(
    parameter  int MAX = 32,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == W'(MAX));

endmodule

// File: rtl/ack_scheduler.sv
// rtl/ack_scheduler.sv - decides piggyback vs. full-ACK LLCRD return of pending retry ACKs
//  i_clk, i_rst_n : clock, synchronous active-low reset
//  bus (slave)    : ACK counter status/decrement, flit packer handshake + ACK bit,
//                   TX arbiter LLCRD request/grant and full-ACK count
module ack_scheduler
    import ack_sched_pkg::*;
#(
    parameter int ACK_TIMEOUT = 32,
    parameter int FULL_THRESH = 192
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    ack_scheduler_if.slave  bus
);

    ack_state_e state_q, state_d;

    logic fire;
    logic active;
    logic cnt_nz;
    logic cnt_full;
    logic piggyback;
    logic full_sent;
    logic timer_tc;

    assign fire     = bus.i_tx_flit_valid & bus.i_tx_flit_ready;
    // Reset is folded in so a grant landing in the reset cycle cannot
    // make the counter drop ACKs that were never sent.
    assign active   = i_rst_n & bus.i_ack_en;
    assign cnt_nz   = (bus.i_retry_num_ack != '0);
    assign cnt_full = (bus.i_retry_num_ack >= CNT_W'(FULL_THRESH));

    // Only IDLE may piggyback: in REQ/COOL the counter is being (or was just)
    // zeroed by the LLCRD, so a second decrement would underflow it.
    assign piggyback = active & bus.i_retry_set_ack_bit & fire & (state_q == IDLE);
    assign full_sent = active & (state_q == REQ) & bus.i_llcrd_gnt;

    ack_timeout_timer #(
        .MAX (ACK_TIMEOUT)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!bus.i_ack_en || !cnt_nz || piggyback || full_sent),
        .i_en    (state_q == IDLE),
        .o_tc    (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A simultaneous piggyback takes priority; the request is
                // re-evaluated next cycle against the reduced count.
                if (cnt_nz && (timer_tc || cnt_full || bus.i_force_ack) && !piggyback) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.i_llcrd_gnt) begin
                    state_d = COOL;
                end
            end
            // One cycle for the counter to reflect the full subtraction
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.i_ack_en) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.o_tx_ack_bit          = piggyback;
    assign bus.o_dec_num_ack         = piggyback;
    assign bus.o_llcrd_req           = (state_q == REQ);
    assign bus.o_llcrd_full_ack_sent = full_sent;
    assign bus.o_llcrd_ack_cnt       = (active && (state_q == REQ)) ? bus.i_retry_num_ack : '0;

endmodule

// File: tb/tb_ack_scheduler.sv
// tb/tb_ack_scheduler.sv - directed self-checking bench for ack_scheduler
module tb_ack_scheduler;
    import ack_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ack_scheduler_if bus ();

    ack_scheduler #(
        .ACK_TIMEOUT (32),
        .FULL_THRESH (192)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Simple ACK counter partner: registered count, set_ack_bit at >= 8
    logic [7:0] cnt;
    logic       load;
    logic [7:0] load_val;

    always @(posedge clk) begin
        if (load)
            cnt <= load_val;
        else
            cnt <= cnt - (bus.o_dec_num_ack ? 8'(ACK_CHUNK) : 8'd0)
                       - (bus.o_llcrd_full_ack_sent ? bus.o_llcrd_ack_cnt : 8'd0);
    end

    assign bus.i_retry_num_ack     = cnt;
    assign bus.i_retry_set_ack_bit = (cnt >= 8'(ACK_CHUNK));

    int passed = 0;
    int total  = 0;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cnt(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick;
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 1'b1; load_val = 8'd0;
        tick; tick;
        load = 1'b0;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.o_llcrd_req); else passed++;
        total++; if (bus.o_tx_ack_bit !== 1'b0) $display("FAIL reset_ack_bit: got %b want 0", bus.o_tx_ack_bit); else passed++;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b0) $display("FAIL reset_sent: got %b want 0", bus.o_llcrd_full_ack_sent); else passed++;
        total++; if (bus.o_llcrd_ack_cnt !== 8'd0) $display("FAIL reset_ack_cnt: got %0d want 0", bus.o_llcrd_ack_cnt); else passed++;
        total++; if (dut.u_timer.cnt_q !== 6'd0) $display("FAIL reset_timer: got %0d want 0", dut.u_timer.cnt_q); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want 0", dut.state_q); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_piggyback;
        load_cnt(8'd8);
        bus.i_tx_flit_valid = 1'b1; bus.i_tx_flit_ready = 1'b1;
        #1;
        total++; if (bus.o_tx_ack_bit !== 1'b1) $display("FAIL pb_ack_bit: got %b want 1", bus.o_tx_ack_bit); else passed++;
        total++; if (bus.o_dec_num_ack !== 1'b1) $display("FAIL pb_dec: got %b want 1", bus.o_dec_num_ack); else passed++;
        tick;
        bus.i_tx_flit_valid = 1'b0; bus.i_tx_flit_ready = 1'b0;
        total++; if (cnt !== 8'd0) $display("FAIL pb_count: got %0d want 0", cnt); else passed++;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL pb_no_req: got %b want 0", bus.o_llcrd_req); else passed++;
    endtask

    task automatic test_timeout;
        load_cnt(8'd3);
        repeat (31) tick;
        total++; if (dut.u_timer.cnt_q !== 6'd31) $display("FAIL to_timer31: got %0d want 31", dut.u_timer.cnt_q); else passed++;
        tick;
        total++; if (dut.u_timer.cnt_q !== 6'd32) $display("FAIL to_timer32: got %0d want 32", dut.u_timer.cnt_q); else passed++;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL to_req_early: got %b want 0", bus.o_llcrd_req); else passed++;
        tick;
        total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL to_req_rise: got %b want 1", bus.o_llcrd_req); else passed++;
        bus.i_llcrd_gnt = 1'b1;
        #1;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b1) $display("FAIL to_sent: got %b want 1", bus.o_llcrd_full_ack_sent); else passed++;
        total++; if (bus.o_llcrd_ack_cnt !== 8'd3) $display("FAIL to_ack_cnt: got %0d want 3", bus.o_llcrd_ack_cnt); else passed++;
        tick;
        bus.i_llcrd_gnt = 1'b0;
        total++; if (dut.state_q !== COOL) $display("FAIL to_cool: got %0d want 2", dut.state_q); else passed++;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL to_cool_req: got %b want 0", bus.o_llcrd_req); else passed++;
        total++; if (cnt !== 8'd0) $display("FAIL to_count: got %0d want 0", cnt); else passed++;
        tick;
        total++; if (dut.state_q !== IDLE) $display("FAIL to_idle: got %0d want 0", dut.state_q); else passed++;
    endtask

    task automatic test_full_thresh;
        load_cnt(8'd192);
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL ft_req_pre: got %b want 0", bus.o_llcrd_req); else passed++;
        tick;
        total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL ft_req: got %b want 1", bus.o_llcrd_req); else passed++;
        bus.i_llcrd_gnt = 1'b1; bus.i_tx_flit_valid = 1'b1; bus.i_tx_flit_ready = 1'b1;
        #1;
        total++; if (bus.o_tx_ack_bit !== 1'b0) $display("FAIL ft_ack_bit: got %b want 0", bus.o_tx_ack_bit); else passed++;
        total++; if (bus.o_dec_num_ack !== 1'b0) $display("FAIL ft_dec: got %b want 0", bus.o_dec_num_ack); else passed++;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b1) $display("FAIL ft_sent: got %b want 1", bus.o_llcrd_full_ack_sent); else passed++;
        total++; if (bus.o_llcrd_ack_cnt !== 8'd192) $display("FAIL ft_ack_cnt: got %0d want 192", bus.o_llcrd_ack_cnt); else passed++;
        tick;
        bus.i_llcrd_gnt = 1'b0; bus.i_tx_flit_valid = 1'b0; bus.i_tx_flit_ready = 1'b0;
        total++; if (cnt !== 8'd0) $display("FAIL ft_count: got %0d want 0", cnt); else passed++;
        tick;
    endtask

    task automatic test_force_hold;
        bus.i_force_ack = 1'b1;
        load_cnt(8'd5);
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL fh_req_pre: got %b want 0", bus.o_llcrd_req); else passed++;
        tick;
        total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL fh_req: got %b want 1", bus.o_llcrd_req); else passed++;
        for (int i = 0; i < 10; i++) begin
            tick;
            total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL fh_hold_req[%0d]: got %b want 1", i, bus.o_llcrd_req); else passed++;
            total++; if (dut.u_timer.cnt_q !== 6'd1) $display("FAIL fh_hold_timer[%0d]: got %0d want 1", i, dut.u_timer.cnt_q); else passed++;
        end
        bus.i_ack_en = 1'b0; bus.i_llcrd_gnt = 1'b1;
        #1;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b0) $display("FAIL fh_off_sent: got %b want 0", bus.o_llcrd_full_ack_sent); else passed++;
        total++; if (bus.o_llcrd_ack_cnt !== 8'd0) $display("FAIL fh_off_ack_cnt: got %0d want 0", bus.o_llcrd_ack_cnt); else passed++;
        tick;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL fh_off_req: got %b want 0", bus.o_llcrd_req); else passed++;
        total++; if (dut.u_timer.cnt_q !== 6'd0) $display("FAIL fh_off_timer: got %0d want 0", dut.u_timer.cnt_q); else passed++;
        total++; if (cnt !== 8'd5) $display("FAIL fh_off_count: got %0d want 5", cnt); else passed++;
        bus.i_llcrd_gnt = 1'b0; bus.i_ack_en = 1'b1; bus.i_force_ack = 1'b0;
        load_cnt(8'd0);
    endtask

    task automatic test_zero_in_req;
        bus.i_force_ack = 1'b1;
        load_cnt(8'd5);
        tick;
        bus.i_force_ack = 1'b0;
        load_cnt(8'd0);
        total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL zr_req: got %b want 1", bus.o_llcrd_req); else passed++;
        bus.i_llcrd_gnt = 1'b1;
        #1;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b1) $display("FAIL zr_sent: got %b want 1", bus.o_llcrd_full_ack_sent); else passed++;
        total++; if (bus.o_llcrd_ack_cnt !== 8'd0) $display("FAIL zr_ack_cnt: got %0d want 0", bus.o_llcrd_ack_cnt); else passed++;
        tick;
        bus.i_llcrd_gnt = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [2:0] want_bits;
        want_bits = 3'b011;
        load_cnt(8'd16);
        bus.i_tx_flit_valid = 1'b1; bus.i_tx_flit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.o_tx_ack_bit !== want_bits[i]) $display("FAIL b2b_ack_bit[%0d]: got %b want %b", i, bus.o_tx_ack_bit, want_bits[i]); else passed++;
            tick;
        end
        bus.i_tx_flit_valid = 1'b0; bus.i_tx_flit_ready = 1'b0;
        total++; if (cnt !== 8'd0) $display("FAIL b2b_count: got %0d want 0", cnt); else passed++;
        total++; if (dut.u_timer.cnt_q !== 6'd0) $display("FAIL b2b_timer: got %0d want 0", dut.u_timer.cnt_q); else passed++;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL b2b_req: got %b want 0", bus.o_llcrd_req); else passed++;
    endtask

    task automatic test_ack_en_gate;
        load_cnt(8'd8);
        bus.i_ack_en = 1'b0; bus.i_tx_flit_valid = 1'b1; bus.i_tx_flit_ready = 1'b1;
        #1;
        total++; if (bus.o_tx_ack_bit !== 1'b0) $display("FAIL en_ack_bit: got %b want 0", bus.o_tx_ack_bit); else passed++;
        total++; if (bus.o_dec_num_ack !== 1'b0) $display("FAIL en_dec: got %b want 0", bus.o_dec_num_ack); else passed++;
        tick;
        total++; if (cnt !== 8'd8) $display("FAIL en_count: got %0d want 8", cnt); else passed++;
        bus.i_ack_en = 1'b1; bus.i_tx_flit_valid = 1'b0; bus.i_tx_flit_ready = 1'b0;
        load_cnt(8'd0);
    endtask

    task automatic test_reset_mid_req;
        bus.i_force_ack = 1'b1;
        load_cnt(8'd5);
        tick;
        total++; if (bus.o_llcrd_req !== 1'b1) $display("FAIL rr_req: got %b want 1", bus.o_llcrd_req); else passed++;
        rst_n = 1'b0; bus.i_llcrd_gnt = 1'b1;
        #1;
        total++; if (bus.o_llcrd_full_ack_sent !== 1'b0) $display("FAIL rr_sent: got %b want 0", bus.o_llcrd_full_ack_sent); else passed++;
        tick;
        total++; if (bus.o_llcrd_req !== 1'b0) $display("FAIL rr_req_drop: got %b want 0", bus.o_llcrd_req); else passed++;
        total++; if (dut.u_timer.cnt_q !== 6'd0) $display("FAIL rr_timer: got %0d want 0", dut.u_timer.cnt_q); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL rr_state: got %0d want 0", dut.state_q); else passed++;
        total++; if (cnt !== 8'd5) $display("FAIL rr_count: got %0d want 5", cnt); else passed++;
        rst_n = 1'b1; bus.i_llcrd_gnt = 1'b0; bus.i_force_ack = 1'b0;
        load_cnt(8'd8);
        bus.i_tx_flit_valid = 1'b1; bus.i_tx_flit_ready = 1'b1;
        #1;
        total++; if (bus.o_tx_ack_bit !== 1'b1) $display("FAIL rr_restart_pb: got %b want 1", bus.o_tx_ack_bit); else passed++;
        tick;
        bus.i_tx_flit_valid = 1'b0; bus.i_tx_flit_ready = 1'b0;
        total++; if (cnt !== 8'd0) $display("FAIL rr_restart_count: got %0d want 0", cnt); else passed++;
    endtask

    initial begin
        rst_n               = 1'b0;
        load                = 1'b1;
        load_val            = 8'd0;
        bus.i_ack_en        = 1'b1;
        bus.i_force_ack     = 1'b0;
        bus.i_tx_flit_valid = 1'b0;
        bus.i_tx_flit_ready = 1'b0;
        bus.i_llcrd_gnt     = 1'b0;
        @(negedge clk);
        test_reset;
        test_piggyback;
        test_timeout;
        test_full_thresh;
        test_force_hold;
        test_zero_in_req;
        test_back_to_back;
        test_ack_en_gate;
        test_reset_mid_req;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
